line_merge_buffer: RTL and testbench

LINE_MERGE_BUFFER -- requirements
Module: line_merge_buffer

---
 rtl/line_merge_buffer.sv | 125 ++++++++++++
 tb/tb_line_merge_buffer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/line_merge_buffer.sv
// Collects byte-enabled word writes into one cache line and presents the merged line on a fill or a flush.
// Latency: out_valid rises on the cycle after the write that fills the line, or after the write/flush that starts a drain.
// Backpressure: wr_ready is low while a line is presented; out_line and out_word_mask hold until out_ready.
module line_merge_buffer #(
  parameter int OFFSET_BITS = 3,
  parameter int WORD_W      = 16,
  localparam int LINE_WORDS = 2**OFFSET_BITS,
  localparam int BYTES      = WORD_W / 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [OFFSET_BITS-1:0]       wr_offset,
  input  logic [WORD_W-1:0]            wr_data,
  input  logic [BYTES-1:0]             wr_be,
  input  logic                         flush_req,
  output logic [LINE_WORDS-1:0]        word_enable,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LINE_WORDS*WORD_W-1:0] out_line,
  output logic [LINE_WORDS-1:0]        out_word_mask
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                         state_q;
  state_t                         state_d;
  logic [LINE_WORDS-1:0]          mask_q;
  logic [LINE_WORDS-1:0]          mask_merged;
  logic [LINE_WORDS*WORD_W-1:0]   line_q;
  logic [LINE_WORDS*WORD_W-1:0]   line_d;
  logic                           wr_take;
  logic                           wr_merge;
  logic                           out_fire;
  logic                           line_full;

  // One-hot decode of the write offset, independent of buffer state.
  always_comb begin
    word_enable            = '0;
    word_enable[wr_offset] = 1'b1;
  end

  // wr_ready is also gated by reset so nothing is accepted while held in reset.
  assign wr_ready  = reset_n && (state_q != DRAIN);
  assign wr_take   = wr_valid && wr_ready;
  // An all-zero byte enable consumes the write but neither marks the word nor moves the FSM.
  assign wr_merge  = wr_take && (|wr_be);
  assign mask_merged = mask_q | (wr_merge ? word_enable : '0);
  assign line_full = &mask_merged;

  assign out_valid     = (state_q == DRAIN);
  assign out_fire      = out_valid && out_ready;
  assign out_line      = line_q;
  assign out_word_mask = mask_q;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a flush only drains once at least one word has been written.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (wr_merge) begin
          state_d = (line_full || flush_req) ? DRAIN : ACCUM;
        end
      end
      ACCUM: begin
        if (line_full || flush_req) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_fire) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Written-word mask: accumulates until the drained line is taken, then clears.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
    end else if (out_fire) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_merged;
    end
  end

  // Byte-granular merge of the accepted write into the addressed word.
  always_comb begin
    line_d = line_q;
    for (int w = 0; w < LINE_WORDS; w++) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wr_take && word_enable[w] && wr_be[b]) begin
          line_d[w*WORD_W + b*8 +: 8] = wr_data[b*8 +: 8];
        end
      end
    end
  end

  // Line storage; a completed drain leaves the data in place, only the mask clears.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

endmodule

// File: tb/tb_line_merge_buffer.sv
module tb_line_merge_buffer;

  localparam int OB = 3;
  localparam int WW = 16;
  localparam int LW = 8;
  localparam int BY = 2;

  logic              clk;
  logic              reset_n;
  logic              wr_valid;
  logic              wr_ready;
  logic [OB-1:0]     wr_offset;
  logic [WW-1:0]     wr_data;
  logic [BY-1:0]     wr_be;
  logic              flush_req;
  logic [LW-1:0]     word_enable;
  logic              out_valid;
  logic              out_ready;
  logic [LW*WW-1:0]  out_line;
  logic [LW-1:0]     out_word_mask;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [LW*WW-1:0] exp_line;

  line_merge_buffer #(.OFFSET_BITS(OB), .WORD_W(WW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_offset     (wr_offset),
    .wr_data       (wr_data),
    .wr_be         (wr_be),
    .flush_req     (flush_req),
    .word_enable   (word_enable),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_line      (out_line),
    .out_word_mask (out_word_mask)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive_write(input logic [OB-1:0] off, input logic [WW-1:0] dat,
                             input logic [BY-1:0] be, input logic fl);
    wr_valid  = 1'b1;
    wr_offset = off;
    wr_data   = dat;
    wr_be     = be;
    flush_req = fl;
  endtask

  task automatic idle();
    wr_valid  = 1'b0;
    wr_be     = '0;
    flush_req = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    wr_valid  = 1'b0;
    wr_offset = '0;
    wr_data   = '0;
    wr_be     = '0;
    flush_req = 1'b0;
    out_ready = 1'b0;

    // Reset state
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_mask", out_word_mask, 0);
    chk("rst_line", out_line, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("post_rst_wr_ready", wr_ready, 1);

    // Offset decode sweep
    for (int i = 0; i < LW; i++) begin
      wr_offset = i[OB-1:0];
      #1;
      chk("word_enable", word_enable, 128'(1) << i);
    end

    // Full line by eight writes
    @(negedge clk);
    exp_line = '0;
    for (int i = 0; i < LW; i++) begin
      chk("fill_no_valid_yet", out_valid, 0);
      chk("fill_wr_ready", wr_ready, 1);
      drive_write(i[OB-1:0], 16'h1000 + 16'(i), 2'b11, 1'b0);
      exp_line[i*WW +: WW] = 16'h1000 + 16'(i);
      @(negedge clk);
    end
    idle();
    out_ready = 1'b1;
    chk("fill_out_valid", out_valid, 1);
    chk("fill_mask", out_word_mask, 8'hFF);
    chk("fill_line", out_line, exp_line);
    chk("fill_wr_ready_drain", wr_ready, 0);
    @(negedge clk);
    out_ready = 1'b0;
    chk("fill_done_valid", out_valid, 0);
    chk("fill_done_mask", out_word_mask, 0);
    chk("fill_done_wr_ready", wr_ready, 1);
    chk("fill_line_kept", out_line, exp_line);

    // Byte-enable merge then flush
    drive_write(3'd2, 16'hABCD, 2'b11, 1'b0);
    @(negedge clk);
    chk("merge_accum_mask", out_word_mask, 8'h04);
    chk("merge_accum_valid", out_valid, 0);
    drive_write(3'd2, 16'h1234, 2'b01, 1'b0);
    @(negedge clk);
    idle();
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    chk("merge_valid", out_valid, 1);
    chk("merge_mask", out_word_mask, 8'h04);
    chk("merge_word2", out_line[2*WW +: WW], 16'hAB34);
    @(negedge clk);
    chk("merge_hold_valid", out_valid, 1);
    chk("merge_hold_word2", out_line[2*WW +: WW], 16'hAB34);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("merge_done_valid", out_valid, 0);

    // Write plus flush from EMPTY, consumer stalls for three cycles
    drive_write(3'd5, 16'h5555, 2'b11, 1'b1);
    @(negedge clk);
    drive_write(3'd0, 16'hDEAD, 2'b11, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_mask", out_word_mask, 8'h20);
      chk("stall_wr_ready", wr_ready, 0);
      @(negedge clk);
    end
    chk("stall_word0_untouched", out_line[0 +: WW], 16'h1000);
    chk("stall_word5", out_line[5*WW +: WW], 16'h5555);
    idle();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("stall_done_valid", out_valid, 0);
    chk("stall_done_mask", out_word_mask, 0);

    // Flush ignored in EMPTY, zero byte-enable write with flush ignored
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    chk("empty_flush_valid", out_valid, 0);
    chk("empty_flush_mask", out_word_mask, 0);
    drive_write(3'd3, 16'hFFFF, 2'b00, 1'b1);
    chk("be0_wr_ready", wr_ready, 1);
    @(negedge clk);
    idle();
    chk("be0_valid", out_valid, 0);
    chk("be0_mask", out_word_mask, 0);
    chk("be0_word3", out_line[3*WW +: WW], 16'h1003);
    @(negedge clk);
    chk("be0_valid_later", out_valid, 0);

    // Write merged in the same cycle as a flush from ACCUM
    drive_write(3'd0, 16'h0A0A, 2'b11, 1'b0);
    @(negedge clk);
    drive_write(3'd6, 16'h6666, 2'b11, 1'b1);
    @(negedge clk);
    idle();
    chk("accflush_valid", out_valid, 1);
    chk("accflush_mask", out_word_mask, 8'h41);
    chk("accflush_word6", out_line[6*WW +: WW], 16'h6666);
    chk("accflush_word0", out_line[0 +: WW], 16'h0A0A);

    // Reset asserted during DRAIN
    #2;
    reset_n = 1'b0;
    #1;
    chk("drain_rst_valid", out_valid, 0);
    chk("drain_rst_mask", out_word_mask, 0);
    chk("drain_rst_line", out_line, 0);
    chk("drain_rst_wr_ready", wr_ready, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("drain_rel_wr_ready", wr_ready, 1);
    chk("drain_rel_valid", out_valid, 0);

    // Reset asserted mid-ACCUM discards the partial line
    @(negedge clk);
    drive_write(3'd4, 16'h4444, 2'b11, 1'b0);
    @(negedge clk);
    idle();
    chk("accum_mask", out_word_mask, 8'h10);
    reset_n = 1'b0;
    #1;
    chk("accum_rst_mask", out_word_mask, 0);
    @(negedge clk);
    reset_n = 1'b1;
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    chk("accum_rst_no_drain", out_valid, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
